// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   state_e     : scanner FSM states
//   ROW_IDLE    : row drive pattern out of reset (row 0 low)
//   COL_NONE    : column pattern with no key pressed (pull-ups)
//   row_onecold : row index -> one-cold row drive pattern
//   lowest_col  : index of lowest-numbered low column (priority encode)
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  localparam logic [3:0] ROW_IDLE = 4'b1110;
  localparam logic [3:0] COL_NONE = 4'b1111;

  function automatic logic [3:0] row_onecold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Scan downward so the lowest low column wins.
  function automatic logic [1:0] lowest_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchroniser for the asynchronous keypad column inputs.
//   clk      : system clock
//   rst      : asynchronous active-high reset, flops go to all-ones (no key)
//   col_in   : raw active-low columns
//   col_sync : synchronised columns
module keypad_scanner_sync
  import keypad_scanner_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] col_sync
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= COL_NONE;
      sync_q <= COL_NONE;
    end else begin
      meta_q <= col_in;
      sync_q <= meta_q;
    end
  end

  assign col_sync = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. Drives one row low at a time for SCAN_DIV cycles,
// samples synchronised columns on the last cycle of each dwell, debounces a press
// over DEBOUNCE_SCANS samples and reports the key as row*4+col.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   col_in    : keypad columns, active-low, asynchronous
//   row_out   : keypad rows, one-cold
//   key_code  : last accepted key, held until the next accepted press
//   key_valid : one-cycle strobe on acceptance
//   key_held  : high from acceptance until the release is debounced
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned CntW   = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntDone   = CntW'(DEBOUNCE_SCANS);

  logic [3:0] col_sync;

  keypad_scanner_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .col_sync (col_sync)
  );

  state_e            state_q, state_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [1:0]        cap_col_q, cap_col_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic [3:0]        row_out_q;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;

  logic       sample;
  logic       pressed;
  logic [1:0] col_idx;

  assign sample  = (dwell_q == DwellLast);
  assign pressed = (col_sync != COL_NONE);
  assign col_idx = lowest_col(col_sync);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    dwell_d     = sample ? '0 : dwell_q + 1'b1;
    row_idx_d   = row_idx_q;
    cap_col_d   = cap_col_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    // Rows only move on a sample, so every sample sees a full dwell of settling.
    if (sample) begin
      unique case (state_q)
        ST_SCAN: begin
          if (!pressed) begin
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            cap_col_d = col_idx;
            if (DEBOUNCE_SCANS == 1) begin
              key_code_d  = {row_idx_q, col_idx};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = ST_HELD;
            end else begin
              cnt_d   = CntW'(1);
              state_d = ST_DEBOUNCE;
            end
          end
        end

        ST_DEBOUNCE: begin
          if (pressed && (col_idx == cap_col_q)) begin
            if (cnt_inc == CntDone) begin
              key_code_d  = {row_idx_q, cap_col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = ST_HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d     = '0;
            state_d   = ST_SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end
        end

        ST_HELD: begin
          // Any column in the frozen row keeps the hold alive.
          if (pressed) begin
            cnt_d = '0;
          end else if (cnt_inc == CntDone) begin
            cnt_d      = '0;
            key_held_d = 1'b0;
            state_d    = ST_SCAN;
            row_idx_d  = row_idx_q + 2'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      dwell_q     <= '0;
      row_idx_q   <= 2'd0;
      cap_col_q   <= 2'd0;
      cnt_q       <= '0;
      row_out_q   <= ROW_IDLE;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      cap_col_q   <= cap_col_d;
      cnt_q       <= cnt_d;
      row_out_q   <= row_onecold(row_idx_d);
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row_out   = row_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV=8, DEBOUNCE_SCANS=3).
// Stimulus pushes the expected key code per intended press; the monitor pops
// and compares on every key_valid pulse.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = 16'd0;   // bit r*4+c set = key (r,c) pressed

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_valid = 0;
  logic [3:0]  exp_q[$];
  logic        prev_valid = 1'b0;
  logic        prev_held = 1'b0;

  keypad_scanner #(
    .SCAN_DIV       (8),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: column c pulled low when its row is driven low and the key is down.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: key_code=%0d, expected no pulse", key_code);
      end else begin
        check("key_code_on_valid", 32'(key_code), 32'(exp_q.pop_front()));
      end
      check("valid_not_after_valid_or_held", {30'd0, prev_valid, prev_held}, 32'd0);
      check("held_with_valid", 32'(key_held), 32'd1);
    end
    prev_valid = key_valid;
    prev_held  = key_held;
  end

  task automatic wait_held_low(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!key_held) break;
    end
    check("held_release", 32'(key_held), 32'd0);
  endtask

  task automatic wait_row(input logic [3:0] row, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (row_out == row) break;
    end
    check("reach_row", 32'(row_out), 32'(row));
  endtask

  logic [3:0] row_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    // 1: reset, then an asynchronous reset mid-dwell
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_row", 32'(row_out), 32'hE);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2: idle scan, rows rotate every 8 clocks
    repeat (4) @(negedge clk);
    check("scan_row0", 32'(row_out), 32'(row_seq[0]));
    for (int i = 1; i < 5; i++) begin
      repeat (8) @(negedge clk);
      check("scan_row", 32'(row_out), 32'(row_seq[i]));
    end

    // 3: key (2,1) -> code 9, release resumes at row 3
    exp_q.push_back(4'd9);
    keys[9] = 1'b1;
    repeat (200) @(negedge clk);
    check("k9_held", 32'(key_held), 32'd1);
    check("k9_code", 32'(key_code), 32'd9);
    keys[9] = 1'b0;
    wait_held_low(60);
    check("k9_resume_row3", 32'(row_out), 32'h7);

    // 4: bounce on (1,3): two samples only
    wait_row(4'b1101, 40);
    keys[7] = 1'b1;
    repeat (16) @(negedge clk);
    keys[7] = 1'b0;
    repeat (8) @(negedge clk);
    check("bounce_row2", 32'(row_out), 32'hB);
    check("bounce_held", 32'(key_held), 32'd0);

    // 5: (0,2)+(0,0) -> code 0; partial release keeps hold
    exp_q.push_back(4'd0);
    keys[2] = 1'b1;
    keys[0] = 1'b1;
    repeat (100) @(negedge clk);
    check("two_held", 32'(key_held), 32'd1);
    check("two_code", 32'(key_code), 32'd0);
    keys[0] = 1'b0;
    repeat (60) @(negedge clk);
    check("two_partial_held", 32'(key_held), 32'd1);
    keys[2] = 1'b0;
    wait_held_low(60);
    check("two_resume_row1", 32'(row_out), 32'hD);

    // 6: hold (3,3), reset while held, re-accept
    exp_q.push_back(4'd15);
    keys[15] = 1'b1;
    repeat (100) @(negedge clk);
    check("k15_held", 32'(key_held), 32'd1);
    check("k15_code", 32'(key_code), 32'd15);
    #2 rst = 1'b1;
    #1;
    check("k15_rst_held", 32'(key_held), 32'd0);
    check("k15_rst_code", 32'(key_code), 32'd0);
    check("k15_rst_row", 32'(row_out), 32'hE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'd15);
    repeat (100) @(negedge clk);
    check("k15_again_held", 32'(key_held), 32'd1);
    check("k15_again_code", 32'(key_code), 32'd15);
    keys[15] = 1'b0;
    wait_held_low(60);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("valid_pulse_count", 32'(n_valid), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
